rggen_irq_coalescer: RTL and testbench

// Parametrised successor to the 2-input irq controller in generated register blocks.

---
 rtl/rggen_rtl_pkg.sv | 16 +
 rtl/rggen_irq_status_cell.sv | 46 ++++
 rtl/rggen_irq_coalescer.sv | 176 +++++++++++++++++
 tb/tb_rggen_irq_coalescer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen interrupt coalescer.
// Contents: coalescing FSM state encoding and per-channel detect-mode encoding.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_IRQ_IDLE  = 2'd0,
      RGGEN_IRQ_ACCUM = 2'd1,
      RGGEN_IRQ_FIRE  = 2'd2
   } rggen_irq_coalesce_state_e;

   typedef enum logic {
      RGGEN_IRQ_LEVEL = 1'b0,
      RGGEN_IRQ_EDGE  = 1'b1
   } rggen_irq_detect_mode_e;

endpackage

// File: rtl/rggen_irq_status_cell.sv
// One interrupt channel: level/rising-edge detection and a sticky status bit
// with write-1-to-clear, where a same-cycle set beats the clear.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   i_src         raw source (synchronous to clk)
//   i_edge_mode   1 = rising-edge detect, 0 = level
//   i_ier         enable, only qualifies the new-event flag
//   i_clear       write-1-to-clear pulse
//   o_isr         registered sticky status bit
//   o_new_c       combinational: enabled event that newly raises the status bit
module rggen_irq_status_cell
   import rggen_rtl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_src,
   input  logic i_edge_mode,
   input  logic i_ier,
   input  logic i_clear,
   output logic o_isr,
   output logic o_new_c
);

   logic                   r_src_prev;
   logic                   r_isr;
   logic                   w_set;
   rggen_irq_detect_mode_e w_mode;

   assign w_mode = rggen_irq_detect_mode_e'(i_edge_mode);
   assign w_set  = (w_mode == RGGEN_IRQ_EDGE) ? (i_src & ~r_src_prev) : i_src;

   // Sticky status; clear is suppressed whenever a set arrives in the same cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_src_prev <= 1'b0;
         r_isr      <= 1'b0;
      end else begin
         r_src_prev <= i_src;
         r_isr      <= (r_isr | w_set) & ~(i_clear & ~w_set);
      end
   end

   assign o_isr   = r_isr;
   assign o_new_c = w_set & ~r_isr & i_ier;

endmodule

// File: rtl/rggen_irq_coalescer.sv
// N-channel interrupt controller with optional event coalescing.
// Sticky per-channel status is masked by enables; the CPU line either follows
// the masked status directly or is held off until a count threshold or timeout.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_irq_src[N]        raw interrupt sources
//   i_edge_mode[N]      per channel 1 = rising edge, 0 = level
//   i_ier[N]            interrupt enables
//   i_isr_clear[N]      write-1-to-clear pulses
//   o_isr[N]            sticky status readback
//   i_coalesce_en       1 = coalescing, 0 = pass-through
//   i_count_threshold   events needed to fire (0 behaves as 1)
//   i_timeout           cycles in ACCUM before forced fire (0 = never)
//   o_irq               registered CPU interrupt
//   o_event_count       registered coalesced event count
module rggen_irq_coalescer
   import rggen_rtl_pkg::*;
#(
   parameter int unsigned TOTAL_INTERRUPTS = 8,
   parameter int unsigned COUNT_WIDTH      = 8,
   parameter int unsigned TIMER_WIDTH      = 16
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [TOTAL_INTERRUPTS-1:0] i_irq_src,
   input  logic [TOTAL_INTERRUPTS-1:0] i_edge_mode,
   input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
   input  logic [TOTAL_INTERRUPTS-1:0] i_isr_clear,
   output logic [TOTAL_INTERRUPTS-1:0] o_isr,
   input  logic                        i_coalesce_en,
   input  logic [COUNT_WIDTH-1:0]      i_count_threshold,
   input  logic [TIMER_WIDTH-1:0]      i_timeout,
   output logic                        o_irq,
   output logic [COUNT_WIDTH-1:0]      o_event_count
);

   localparam int unsigned N     = TOTAL_INTERRUPTS;
   localparam int unsigned NEW_W = $clog2(N + 1);
   localparam int unsigned SUM_W = ((COUNT_WIDTH > NEW_W) ? COUNT_WIDTH : NEW_W) + 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [TIMER_WIDTH-1:0] TMR_MAX = '1;

   logic [N-1:0]              w_isr;
   logic [N-1:0]              w_new;
   logic [NEW_W-1:0]          w_new_cnt;
   logic                      w_active;

   rggen_irq_coalesce_state_e r_state;
   rggen_irq_coalesce_state_e w_state_nxt;
   logic [COUNT_WIDTH-1:0]    r_count;
   logic [COUNT_WIDTH-1:0]    w_count_nxt;
   logic [TIMER_WIDTH-1:0]    r_timer;
   logic [TIMER_WIDTH-1:0]    w_timer_nxt;
   logic                      r_irq;
   logic                      w_irq_nxt;

   logic [COUNT_WIDTH-1:0]    w_base;
   logic [SUM_W-1:0]          w_sum;
   logic [COUNT_WIDTH-1:0]    w_count_sat;
   logic [COUNT_WIDTH-1:0]    w_thr;
   logic                      w_thr_hit;
   logic [TIMER_WIDTH-1:0]    w_timer_plus1;
   logic [TIMER_WIDTH-1:0]    w_timer_step;
   logic                      w_timeout_hit;

   // Per-channel capture
   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      rggen_irq_status_cell u_cell (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_src       (i_irq_src[gi]),
         .i_edge_mode (i_edge_mode[gi]),
         .i_ier       (i_ier[gi]),
         .i_clear     (i_isr_clear[gi]),
         .o_isr       (w_isr[gi]),
         .o_new_c     (w_new[gi])
      );
   end

   // Number of enabled channels that become pending this cycle
   always_comb begin
      w_new_cnt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_new_cnt = w_new_cnt + NEW_W'(w_new[i]);
      end
   end

   assign w_active = |(w_isr & i_ier);

   // Saturating accumulation; IDLE starts from zero so the same adder serves both states
   assign w_base      = (r_state == RGGEN_IRQ_IDLE) ? '0 : r_count;
   assign w_sum       = SUM_W'(w_base) + SUM_W'(w_new_cnt);
   assign w_count_sat = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : COUNT_WIDTH'(w_sum);
   assign w_thr       = (i_count_threshold == '0) ? COUNT_WIDTH'(1) : i_count_threshold;
   assign w_thr_hit   = (w_count_sat >= w_thr);

   // Timer holds at the programmed timeout, or at all-ones when timeout is disabled
   assign w_timer_plus1 = r_timer + TIMER_WIDTH'(1);
   assign w_timer_step  = (((i_timeout != '0) && (r_timer == i_timeout)) || (r_timer == TMR_MAX))
                          ? r_timer : w_timer_plus1;
   assign w_timeout_hit = (i_timeout != '0) && (w_timer_plus1 == i_timeout);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_timer_nxt = r_timer;
      w_irq_nxt   = 1'b0;
      if (!i_coalesce_en) begin
         w_state_nxt = RGGEN_IRQ_IDLE;
         w_count_nxt = '0;
         w_timer_nxt = '0;
         w_irq_nxt   = w_active;
      end else begin
         case (r_state)
            RGGEN_IRQ_IDLE: begin
               w_count_nxt = '0;
               w_timer_nxt = '0;
               if (w_new_cnt != '0) begin
                  w_count_nxt = w_count_sat;
                  w_state_nxt = w_thr_hit ? RGGEN_IRQ_FIRE : RGGEN_IRQ_ACCUM;
               end
            end
            RGGEN_IRQ_ACCUM: begin
               // Nothing left pending: abandon the batch rather than fire an empty interrupt
               if (!w_active && (w_new_cnt == '0)) begin
                  w_state_nxt = RGGEN_IRQ_IDLE;
                  w_count_nxt = '0;
                  w_timer_nxt = '0;
               end else begin
                  w_count_nxt = w_count_sat;
                  w_timer_nxt = w_timer_step;
                  if (w_thr_hit || w_timeout_hit) begin
                     w_state_nxt = RGGEN_IRQ_FIRE;
                  end
               end
            end
            RGGEN_IRQ_FIRE: begin
               w_irq_nxt = w_active;
               if (!w_active) begin
                  w_state_nxt = RGGEN_IRQ_IDLE;
                  w_count_nxt = '0;
                  w_timer_nxt = '0;
               end else begin
                  w_count_nxt = w_count_sat;
               end
            end
            default: begin
               w_state_nxt = RGGEN_IRQ_IDLE;
               w_count_nxt = '0;
               w_timer_nxt = '0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RGGEN_IRQ_IDLE;
         r_count <= '0;
         r_timer <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_timer <= w_timer_nxt;
         r_irq   <= w_irq_nxt;
      end
   end

   assign o_isr         = w_isr;
   assign o_irq         = r_irq;
   assign o_event_count = r_count;

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Directed bench for rggen_irq_coalescer: the stimulus process schedules
// hand-computed expectations into a cycle-ordered queue, and a monitor
// compares them against the DUT outputs on the falling edge.
module tb_rggen_irq_coalescer;

   localparam int unsigned N  = 8;
   localparam int unsigned CW = 8;
   localparam int unsigned TW = 16;

   localparam int M_ISR = 1;
   localparam int M_IRQ = 2;
   localparam int M_CNT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  src;
   logic [N-1:0]  edge_mode;
   logic [N-1:0]  ier;
   logic [N-1:0]  clr;
   logic [N-1:0]  o_isr;
   logic          coal;
   logic [CW-1:0] thr;
   logic [TW-1:0] tmo;
   logic          o_irq;
   logic [CW-1:0] o_cnt;

   rggen_irq_coalescer #(
      .TOTAL_INTERRUPTS (N),
      .COUNT_WIDTH      (CW),
      .TIMER_WIDTH      (TW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_irq_src         (src),
      .i_edge_mode       (edge_mode),
      .i_ier             (ier),
      .i_isr_clear       (clr),
      .o_isr             (o_isr),
      .i_coalesce_en     (coal),
      .i_count_threshold (thr),
      .i_timeout         (tmo),
      .o_irq             (o_irq),
      .o_event_count     (o_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      string      name;
      int         mask;
      logic [7:0] isr;
      logic       irq;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Schedule an expectation d rising edges after the current falling edge
   task automatic expect_at(input int d, input string name, input int mask,
                            input logic [7:0] isr, input logic irq, input logic [7:0] cnt);
      exp_t e;
      int   pos;
      e.cyc  = cyc + d;
      e.name = name;
      e.mask = mask;
      e.isr  = isr;
      e.irq  = irq;
      e.cnt  = cnt;
      pos = q.size();
      for (int i = 0; i < q.size(); i++) begin
         if (q[i].cyc > e.cyc) begin
            pos = i;
            break;
         end
      end
      q.insert(pos, e);
   endtask

   task automatic nxt(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) begin
               n_checks++;
               n_errors++;
               $display("FAIL %s sample missed: scheduled cycle %0d, now %0d", e.name, e.cyc, cyc);
            end else begin
               if ((e.mask & M_ISR) != 0) begin
                  n_checks++;
                  if (o_isr !== e.isr) begin
                     n_errors++;
                     $display("FAIL %s o_isr got %h want %h (cycle %0d)", e.name, o_isr, e.isr, cyc);
                  end
               end
               if ((e.mask & M_IRQ) != 0) begin
                  n_checks++;
                  if (o_irq !== e.irq) begin
                     n_errors++;
                     $display("FAIL %s o_irq got %b want %b (cycle %0d)", e.name, o_irq, e.irq, cyc);
                  end
               end
               if ((e.mask & M_CNT) != 0) begin
                  n_checks++;
                  if (o_cnt !== e.cnt) begin
                     n_errors++;
                     $display("FAIL %s o_event_count got %0d want %0d (cycle %0d)", e.name, o_cnt, e.cnt, cyc);
                  end
               end
            end
         end
      end
   end

   // Stimulus
   initial begin : stim
      rst_n = 1'b0; src = '0; edge_mode = '0; ier = '0; clr = '0;
      coal = 1'b0; thr = 8'd4; tmo = '0;

      // Reset state
      nxt(1);
      expect_at(1, "reset", M_ISR | M_IRQ | M_CNT, 8'h00, 1'b0, 8'd0);
      nxt(1);
      rst_n = 1'b1; ier = 8'hFF;
      nxt(2);

      // Pass-through latency, level ch3
      src = 8'h08;
      expect_at(1, "pt_isr_set", M_ISR | M_IRQ, 8'h08, 1'b0, 8'd0);
      expect_at(2, "pt_irq_set", M_IRQ | M_CNT, 8'h00, 1'b1, 8'd0);
      nxt(3);
      src = 8'h00; clr = 8'h08;
      expect_at(1, "pt_isr_clr", M_ISR | M_IRQ, 8'h00, 1'b1, 8'd0);
      expect_at(2, "pt_irq_clr", M_IRQ, 8'h00, 1'b0, 8'd0);
      nxt(1); clr = '0;
      nxt(3);

      // Edge ch0 vs level ch1 with a clear while the sources stay high
      edge_mode = 8'h01; src = 8'h03;
      expect_at(1, "el_capture", M_ISR, 8'h03, 1'b0, 8'd0);
      nxt(5);
      clr = 8'h03;
      expect_at(1, "el_after_clear", M_ISR, 8'h02, 1'b0, 8'd0);
      nxt(1); clr = '0;
      nxt(3);
      expect_at(1, "el_hold", M_ISR, 8'h02, 1'b0, 8'd0);
      nxt(1);
      src = 8'h00; clr = 8'h03;
      expect_at(1, "el_cleanup", M_ISR, 8'h00, 1'b0, 8'd0);
      nxt(1); clr = '0; edge_mode = 8'h00;
      nxt(2);

      // Simultaneous set and clear on ch2
      src = 8'h04; clr = 8'h04;
      expect_at(1, "sim_set_clr", M_ISR, 8'h04, 1'b0, 8'd0);
      nxt(1); clr = '0;
      nxt(1);
      src = 8'h00; clr = 8'h04;
      expect_at(1, "sim_cleanup", M_ISR, 8'h00, 1'b0, 8'd0);
      nxt(1); clr = '0;
      nxt(2);

      // Disabled channel still sets status but never interrupts
      ier = 8'hEF; src = 8'h10;
      expect_at(1, "mask_isr", M_ISR | M_IRQ, 8'h10, 1'b0, 8'd0);
      expect_at(2, "mask_irq2", M_IRQ, 8'h00, 1'b0, 8'd0);
      expect_at(4, "mask_irq4", M_IRQ, 8'h00, 1'b0, 8'd0);
      nxt(4);
      src = 8'h00; clr = 8'h10;
      expect_at(1, "mask_cleanup", M_ISR, 8'h00, 1'b0, 8'd0);
      nxt(1); clr = '0; ier = 8'hFF;
      nxt(2);

      // Coalescing by count: thr=4, no timeout, events at 0,5,9,20
      edge_mode = 8'hFF; coal = 1'b1; thr = 8'd4; tmo = '0;
      nxt(2);
      for (int k = 0; k < 22; k++) begin
         case (k)
            0:       src = 8'h01;
            5:       src = 8'h02;
            9:       src = 8'h04;
            20:      src = 8'h08;
            default: src = 8'h00;
         endcase
         case (k)
            0:  expect_at(1, "co_cnt1",     M_IRQ | M_CNT, 8'h00, 1'b0, 8'd1);
            4:  expect_at(1, "co_hold1",    M_IRQ | M_CNT, 8'h00, 1'b0, 8'd1);
            5:  expect_at(1, "co_cnt2",     M_IRQ | M_CNT, 8'h00, 1'b0, 8'd2);
            9:  expect_at(1, "co_cnt3",     M_IRQ | M_CNT, 8'h00, 1'b0, 8'd3);
            19: expect_at(1, "co_pre4",     M_IRQ | M_CNT, 8'h00, 1'b0, 8'd3);
            20: expect_at(1, "co_cnt4",     M_IRQ | M_CNT, 8'h00, 1'b0, 8'd4);
            21: expect_at(1, "co_irq_rise", M_IRQ | M_CNT, 8'h00, 1'b1, 8'd4);
            default: ;
         endcase
         nxt(1);
      end
      clr = 8'h0F;
      expect_at(1, "co_clr1", M_ISR | M_IRQ | M_CNT, 8'h00, 1'b1, 8'd4);
      expect_at(2, "co_clr2", M_IRQ | M_CNT, 8'h00, 1'b0, 8'd0);
      nxt(1); clr = '0;
      nxt(2);

      // Coalescing by timeout: thr=4, timeout=16, single event on ch5
      tmo = 16'd16; src = 8'h20;
      expect_at(1,  "to_accum",    M_IRQ | M_CNT, 8'h00, 1'b0, 8'd1);
      expect_at(10, "to_wait",     M_IRQ | M_CNT, 8'h00, 1'b0, 8'd1);
      expect_at(17, "to_pre_fire", M_IRQ | M_CNT, 8'h00, 1'b0, 8'd1);
      expect_at(18, "to_irq",      M_IRQ | M_CNT, 8'h00, 1'b1, 8'd1);
      nxt(1); src = 8'h00;
      nxt(17);
      clr = 8'h20;
      expect_at(1, "to_clr1", M_ISR | M_IRQ | M_CNT, 8'h00, 1'b1, 8'd1);
      expect_at(2, "to_clr2", M_IRQ | M_CNT, 8'h00, 1'b0, 8'd0);
      nxt(1); clr = '0;
      nxt(2);

      // Reset while in FIRE with isr=A5; an edge during reset is dropped
      tmo = '0; src = 8'hA5;
      expect_at(1, "rf_fire",  M_ISR | M_IRQ | M_CNT, 8'hA5, 1'b0, 8'd4);
      expect_at(2, "rf_irq",   M_ISR | M_IRQ | M_CNT, 8'hA5, 1'b1, 8'd4);
      nxt(1); src = 8'h00;
      nxt(1);
      rst_n = 1'b0; src = 8'h02;
      expect_at(1, "rf_reset", M_ISR | M_IRQ | M_CNT, 8'h00, 1'b0, 8'd0);
      nxt(1);
      rst_n = 1'b1; src = 8'h00;
      expect_at(1, "rf_after", M_ISR | M_IRQ | M_CNT, 8'h00, 1'b0, 8'd0);
      expect_at(3, "rf_quiet", M_ISR | M_IRQ | M_CNT, 8'h00, 1'b0, 8'd0);
      nxt(4);

      // Counter saturation with thr=0 (behaves as 1); ch7 held to keep FIRE active
      edge_mode = 8'h00; thr = 8'd0; src = 8'hFF;
      expect_at(1, "sat_first", M_IRQ | M_CNT, 8'h00, 1'b0, 8'd8);
      nxt(1);
      for (int i = 0; i < 40; i++) begin
         src = 8'h80; clr = 8'h7F;
         nxt(1);
         src = 8'hFF; clr = 8'h00;
         nxt(1);
      end
      src = 8'h80; clr = 8'h7F;
      expect_at(1, "sat_max", M_ISR | M_IRQ | M_CNT, 8'h80, 1'b1, 8'd255);
      nxt(1); clr = '0;
      nxt(1);

      // Coalescing disabled while firing, then re-enabled with status pending
      coal = 1'b0;
      expect_at(1, "cen_fall", M_IRQ | M_CNT, 8'h00, 1'b1, 8'd0);
      nxt(2);
      coal = 1'b1; thr = 8'd4;
      expect_at(1, "cen_rise",         M_ISR | M_IRQ | M_CNT, 8'h80, 1'b0, 8'd0);
      expect_at(3, "cen_rise_pending", M_IRQ | M_CNT, 8'h00, 1'b0, 8'd0);
      nxt(3);

      // Drain scheduled expectations, bounded
      for (int w = 0; w < 50 && q.size() > 0; w++) nxt(1);
      if (q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain %0d expectations left unchecked, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
